// File: rtl/fifo_sync_flags_if.sv
// Valid/ready handshake bundle between a producer, the FIFO and a consumer.
// The FIFO takes the slave view. The bench or the surrounding stage drives
// the producer and consumer sides through the master view.
interface fifo_sync_flags_if #(
    parameter int WIDTH_P = 8
);
    logic [WIDTH_P-1:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] data_o;
    logic               valid_o;
    logic               ready_i;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock first-word-fall-through FIFO for same-domain audio buffering.
// It adds an occupancy count, almost-full and almost-empty thresholds, a
// synchronous flush, a sticky overflow flag and a high-water mark.
// The pointers carry one extra wrap bit, so they advance modulo 2*DEPTH_P.
// Full and empty are decided from the registered count.
module fifo_sync_flags #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int AFULL_P  = 12,
    parameter int AEMPTY_P = 4,
    localparam int CW_P    = $clog2(DEPTH_P) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            clr_err_i,
    fifo_sync_flags_if.slave bus,
    output logic [CW_P-1:0] count_o,
    output logic            almost_full_o,
    output logic            almost_empty_o,
    output logic            overflow_o,
    output logic [CW_P-1:0] max_count_o
);
    localparam int              AW_P     = CW_P - 1;
    localparam logic [CW_P-1:0] DEPTH_C  = CW_P'(DEPTH_P);
    localparam logic [CW_P-1:0] AFULL_C  = CW_P'(AFULL_P);
    localparam logic [CW_P-1:0] AEMPTY_C = CW_P'(AEMPTY_P);
    localparam logic [CW_P-1:0] ZERO_C   = CW_P'(0);
    localparam logic [CW_P-1:0] ONE_C    = CW_P'(1);

    logic [WIDTH_P-1:0] mem_r [DEPTH_P];
    logic [CW_P-1:0]    wr_ptr_r;
    logic [CW_P-1:0]    rd_ptr_r;
    logic [CW_P-1:0]    count_r;
    logic [CW_P-1:0]    count_nxt_s;
    logic [CW_P-1:0]    max_count_r;
    logic               overflow_r;
    logic               full_s;
    logic               empty_s;
    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_set_s;

    // ready_o is masked by reset so the producer sees "not ready" while rst_i is high.
    // It never looks at ready_i, so a pop cannot make room for a push in the same cycle.
    assign full_s    = (count_r == DEPTH_C);
    assign empty_s   = (count_r == ZERO_C);
    assign ready_s   = ~full_s & ~rst_i;
    assign push_s    = bus.valid_i & ready_s;
    assign pop_s     = ~empty_s & bus.ready_i;
    assign ovf_set_s = bus.valid_i & ~ready_s;

    assign bus.ready_o    = ready_s;
    assign bus.valid_o    = ~empty_s;
    assign bus.data_o     = mem_r[rd_ptr_r[AW_P-1:0]];
    assign count_o        = count_r;
    assign almost_full_o  = (count_r >= AFULL_C);
    assign almost_empty_o = (count_r <= AEMPTY_C);
    assign overflow_o     = overflow_r;
    assign max_count_o    = max_count_r;

    // Next occupancy: flush wins, otherwise count push/pop net effect
    always_comb begin
        count_nxt_s = count_r;
        if (flush_i) begin
            count_nxt_s = ZERO_C;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + ONE_C;
                2'b01:   count_nxt_s = count_r - ONE_C;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Storage write; a push in a flush cycle is dropped
    always_ff @(posedge clk_i) begin
        if (push_s && !flush_i) begin
            mem_r[wr_ptr_r[AW_P-1:0]] <= bus.data_i;
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
        end else if (flush_i) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky overflow flag; a new refused write beats a clear in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (clr_err_i) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // High-water mark; clearing restarts it from the upcoming occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            max_count_r <= ZERO_C;
        end else if (clr_err_i) begin
            max_count_r <= count_nxt_s;
        end else if (count_nxt_s > max_count_r) begin
            max_count_r <= count_nxt_s;
        end else begin
            max_count_r <= max_count_r;
        end
    end
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags. A queue-based reference model tracks contents,
// the overflow flag and the high-water mark. Inputs change on the falling
// edge, and outputs are compared on the falling edge.
module tb_fifo_sync_flags;
    localparam int WIDTH_P  = 8;
    localparam int DEPTH_P  = 16;
    localparam int AFULL_P  = 12;
    localparam int AEMPTY_P = 4;
    localparam int CW_P     = $clog2(DEPTH_P) + 1;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            clr_err_i;
    logic [CW_P-1:0] count_o;
    logic            almost_full_o;
    logic            almost_empty_o;
    logic            overflow_o;
    logic [CW_P-1:0] max_count_o;

    fifo_sync_flags_if #(.WIDTH_P(WIDTH_P)) bus ();

    fifo_sync_flags #(
        .WIDTH_P(WIDTH_P), .DEPTH_P(DEPTH_P), .AFULL_P(AFULL_P), .AEMPTY_P(AEMPTY_P)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
        .bus(bus), .count_o(count_o), .almost_full_o(almost_full_o),
        .almost_empty_o(almost_empty_o), .overflow_o(overflow_o), .max_count_o(max_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // reference model
    logic [WIDTH_P-1:0] mq[$];
    bit                 m_ovf = 1'b0;
    int                 m_max = 0;

    // one clock edge: model sees the same inputs the DUT samples
    task automatic tick();
        bit p, q, s;
        int n;
        p = bus.valid_i && !rst_i && (mq.size() != DEPTH_P);
        q = bus.ready_i && (mq.size() != 0);
        s = bus.valid_i && (rst_i || mq.size() == DEPTH_P);
        @(posedge clk_i);
        if (flush_i) begin
            mq.delete();
        end else begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(bus.data_i);
        end
        n = mq.size();
        if (s) m_ovf = 1'b1;
        else if (clr_err_i) m_ovf = 1'b0;
        if (clr_err_i) m_max = n;
        else if (n > m_max) m_max = n;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                for (int k = 0; k < 5; k++) begin
                    bus.valid_i = 1'b1; bus.data_i = 8'($urandom);
                    tick();
                end
                bus.valid_i = 1'b0;
                checks++;
                if (count_o !== 5) begin
                    failures++; $display("FAIL pre_reset_count got=%0d exp=5", count_o);
                end
                #2 rst_i = 1'b1;
                mq.delete(); m_ovf = 1'b0; m_max = 0;
            end
            #1;
            checks++;
            if ({bus.ready_o, bus.valid_o, count_o, almost_full_o, almost_empty_o, overflow_o, max_count_o}
                !== {1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0}) begin
                failures++;
                $display("FAIL reset_state ph=%0d rdy=%b vld=%b cnt=%0d af=%b ae=%b ovf=%b max=%0d exp 0 0 0 0 1 0 0",
                         ph, bus.ready_o, bus.valid_o, count_o, almost_full_o, almost_empty_o, overflow_o, max_count_o);
            end
            @(negedge clk_i);
            rst_i = 1'b0;
            #1;
            checks++;
            if (bus.ready_o !== 1'b1 || count_o !== 0) begin
                failures++;
                $display("FAIL reset_release ph=%0d rdy=%b cnt=%0d exp rdy=1 cnt=0", ph, bus.ready_o, count_o);
            end
        end
    endtask

    task automatic test_fill_drain();
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEPTH_P; i++) begin
            bus.valid_i = 1'b1; bus.data_i = 8'(i);
            tick();
            checks++;
            if (count_o !== i + 1 || almost_full_o !== (i + 1 >= AFULL_P) || bus.ready_o !== (i + 1 < DEPTH_P)) begin
                failures++;
                $display("FAIL fill i=%0d cnt=%0d af=%b rdy=%b exp cnt=%0d af=%b rdy=%b", i, count_o,
                         almost_full_o, bus.ready_o, i + 1, (i + 1 >= AFULL_P), (i + 1 < DEPTH_P));
            end
        end
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        for (int i = 0; i < DEPTH_P; i++) begin
            checks++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== 8'(i)) begin
                failures++;
                $display("FAIL drain_data i=%0d vld=%b data=%h exp vld=1 data=%h", i, bus.valid_o, bus.data_o, 8'(i));
            end
            tick();
            checks++;
            if (count_o !== 15 - i || almost_empty_o !== (15 - i <= AEMPTY_P) || bus.valid_o !== (i != 15)) begin
                failures++;
                $display("FAIL drain_flags i=%0d cnt=%0d ae=%b vld=%b exp cnt=%0d ae=%b vld=%b", i, count_o,
                         almost_empty_o, bus.valid_o, 15 - i, (15 - i <= AEMPTY_P), (i != 15));
            end
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        bus.ready_i = 1'b0;
        for (int i = 0; i < DEPTH_P; i++) begin
            bus.valid_i = 1'b1; bus.data_i = 8'($urandom);
            tick();
        end
        bus.data_i = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (overflow_o !== 1'b1 || count_o !== 16 || bus.ready_o !== 1'b0) begin
                failures++;
                $display("FAIL overflow_hold i=%0d ovf=%b cnt=%0d rdy=%b exp ovf=1 cnt=16 rdy=0",
                         i, overflow_o, count_o, bus.ready_o);
            end
        end
        bus.valid_i = 1'b0; clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0 || max_count_o !== 16 || max_count_o !== m_max) begin
            failures++;
            $display("FAIL overflow_clear ovf=%b max=%0d exp ovf=0 max=16", overflow_o, max_count_o);
        end
        bus.ready_i = 1'b1;
        for (int i = 0; i < DEPTH_P; i++) begin
            checks++;
            if (bus.data_o !== mq[0]) begin
                failures++;
                $display("FAIL overflow_data i=%0d got=%h exp=%h", i, bus.data_o, mq[0]);
            end
            tick();
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        bus.valid_i = 1'b1; bus.data_i = 8'h33; bus.ready_i = 1'b0;
        tick();
        bus.data_i = 8'hAA; bus.ready_i = 1'b1;
        tick();
        checks++;
        if (count_o !== 1 || bus.data_o !== 8'hAA || bus.valid_o !== 1'b1) begin
            failures++;
            $display("FAIL simul_count1 cnt=%0d data=%h vld=%b exp cnt=1 data=aa vld=1", count_o, bus.data_o, bus.valid_o);
        end
        for (int i = 0; i < 48; i++) begin
            bus.valid_i = ($urandom_range(0, 3) != 0);
            bus.ready_i = ($urandom_range(0, 1) != 0);
            bus.data_i  = 8'($urandom);
            tick();
            checks++;
            if (count_o !== mq.size() || bus.valid_o !== (mq.size() != 0) || bus.ready_o !== (mq.size() != DEPTH_P) ||
                almost_full_o !== (mq.size() >= AFULL_P) || almost_empty_o !== (mq.size() <= AEMPTY_P) ||
                overflow_o !== m_ovf || max_count_o !== m_max ||
                (mq.size() != 0 && bus.data_o !== mq[0])) begin
                failures++;
                $display("FAIL random i=%0d cnt=%0d/%0d data=%h/%h ovf=%b/%b max=%0d/%0d af=%b ae=%b rdy=%b",
                         i, count_o, mq.size(), bus.data_o, (mq.size() != 0) ? mq[0] : 8'h00,
                         overflow_o, m_ovf, max_count_o, m_max, almost_full_o, almost_empty_o, bus.ready_o);
            end
        end
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        for (int i = 0; i < DEPTH_P + 1; i++) begin
            if (mq.size() != 0) begin
                checks++;
                if (bus.data_o !== mq[0]) begin
                    failures++;
                    $display("FAIL random_drain i=%0d got=%h exp=%h", i, bus.data_o, mq[0]);
                end
            end
            tick();
        end
        bus.ready_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || count_o !== 0) begin
            failures++;
            $display("FAIL random_empty vld=%b cnt=%0d exp vld=0 cnt=0", bus.valid_o, count_o);
        end
    endtask

    task automatic test_flush();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.valid_i = 1'b1; bus.data_i = 8'(8'h40 + i);
            tick();
        end
        flush_i = 1'b1; bus.data_i = 8'h99; bus.ready_i = 1'b1;
        #1;
        checks++;
        if (count_o !== 7 || bus.ready_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre cnt=%0d rdy=%b exp cnt=7 rdy=1", count_o, bus.ready_o);
        end
        tick();
        flush_i = 1'b0; bus.ready_i = 1'b0;
        checks++;
        if (count_o !== 0 || bus.valid_o !== 1'b0 || max_count_o !== 7 || count_o !== mq.size()) begin
            failures++;
            $display("FAIL flush_post cnt=%0d vld=%b max=%0d exp cnt=0 vld=0 max=7", count_o, bus.valid_o, max_count_o);
        end
        bus.data_i = 8'h11;
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (count_o !== 1 || bus.data_o !== 8'h11) begin
            failures++;
            $display("FAIL flush_next cnt=%0d data=%h exp cnt=1 data=11", count_o, bus.data_o);
        end
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    task automatic test_latency();
        bus.valid_i = 1'b1; bus.data_i = 8'h5C;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL latency_before vld=%b exp=0", bus.valid_o);
        end
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h5C || count_o !== 1) begin
            failures++;
            $display("FAIL latency_after vld=%b data=%h cnt=%0d exp vld=1 data=5c cnt=1", bus.valid_o, bus.data_o, count_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; clr_err_i = 1'b0;
        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.data_i = 8'h00;
        @(negedge clk_i);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_flush();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
